// File: rtl/boid_frame_writer_if.sv
// rtl/boid_frame_writer_if.sv - boid position read port and framebuffer write port
//
// Groups the two memory-facing buses of the frame writer:
//   boid_pos_addr  : boid position memory read index (writer -> memory)
//   boid_pos_x/y   : boid screen position, valid one clk after the index
//   fb_write_addr  : framebuffer write address (writer -> framebuffer)
//   fb_write_data  : framebuffer write bit
//   fb_write_en    : framebuffer write strobe
// master = frame writer, slave = memories.
interface boid_frame_writer_if #(
    parameter int IDX_WIDTH  = 5,
    parameter int ADDR_WIDTH = 20
);
    logic [IDX_WIDTH-1:0]  boid_pos_addr;
    logic [9:0]            boid_pos_x;
    logic [8:0]            boid_pos_y;
    logic [ADDR_WIDTH-1:0] fb_write_addr;
    logic                  fb_write_data;
    logic                  fb_write_en;

    modport master (
        output boid_pos_addr,
        input  boid_pos_x,
        input  boid_pos_y,
        output fb_write_addr,
        output fb_write_data,
        output fb_write_en
    );

    modport slave (
        input  boid_pos_addr,
        output boid_pos_x,
        output boid_pos_y,
        input  fb_write_addr,
        input  fb_write_data,
        input  fb_write_en
    );
endinterface

// File: rtl/boid_frame_writer.sv
// rtl/boid_frame_writer.sv - clears the 1-bit boid framebuffer and plots every boid once per frame
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   frame_start  : end-of-screen level; only its rising edge starts a frame
//   bus          : boid position read port and framebuffer write port (master side)
//   busy         : high from the first clear write through the last plot write
//   frame_done   : one-cycle pulse after a frame has been completely written
//   overrun      : sticky, a frame start arrived while a frame was in progress
//   clip_count   : boids skipped as off-screen in the last completed frame (saturating)
module boid_frame_writer #(
    parameter int NUM_BOIDS  = 32,
    parameter int IDX_WIDTH  = 5,
    parameter int FB_DEPTH   = 153600,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    boid_frame_writer_if.master    bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic [7:0]             clip_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RD    = 3'd2,
        S_WAIT  = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic [IDX_WIDTH-1:0]  IDX_LAST   = IDX_WIDTH'(NUM_BOIDS - 1);

    state_t                state;
    state_t                state_nxt;

    logic                  fs_q;
    logic                  start;
    logic [ADDR_WIDTH-1:0] ccnt;
    logic [IDX_WIDTH-1:0]  idx;
    logic [9:0]            x_q;
    logic [8:0]            y_q;
    logic [7:0]            clip_work;

    logic                  clear_last;
    logic                  idx_last;
    logic                  on_screen;
    logic [ADDR_WIDTH-1:0] plot_addr;

    // Next values of the registered outputs; every output leaves a flop so
    // that address, data and strobe always change on the same edge.
    logic                  wr_en_d;
    logic                  wr_data_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic                  busy_d;
    logic                  done_d;

    logic                  fb_write_en_q;
    logic                  fb_write_data_q;
    logic [ADDR_WIDTH-1:0] fb_write_addr_q;

    assign start      = frame_start & ~fs_q;
    assign clear_last = (ccnt == CLEAR_LAST);
    assign idx_last   = (idx == IDX_LAST);
    assign on_screen  = (x_q <= 10'd639) && (y_q <= 9'd479);

    // Two framebuffer pixels share one bit horizontally, so the row pitch is
    // 320 words: y*320 = (y<<8) + (y<<6). Everything is widened first so the
    // sum never truncates.
    assign plot_addr = ADDR_WIDTH'(x_q[9:1])
                     + (ADDR_WIDTH'(y_q) << 8)
                     + (ADDR_WIDTH'(y_q) << 6);

    // The index register doubles as the read address: it is loaded on entry
    // to RD, so the memory sees it during RD and returns data during WAIT.
    assign bus.boid_pos_addr = idx;
    assign bus.fb_write_en   = fb_write_en_q;
    assign bus.fb_write_data = fb_write_data_q;
    assign bus.fb_write_addr = fb_write_addr_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: if (clear_last) state_nxt = S_RD;
            S_RD:    state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_WR;
            S_WR:    state_nxt = idx_last ? S_DONE : S_RD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic (values registered on the next edge)
    always_comb begin
        wr_en_d   = 1'b0;
        wr_data_d = 1'b0;
        wr_addr_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state)
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ccnt;
                busy_d    = 1'b1;
            end
            S_RD, S_WAIT: begin
                busy_d = 1'b1;
            end
            S_WR: begin
                busy_d = 1'b1;
                if (on_screen) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = 1'b1;
                    wr_addr_d = plot_addr;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fs_q            <= 1'b0;
            fb_write_en_q   <= 1'b0;
            fb_write_data_q <= 1'b0;
            fb_write_addr_q <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            overrun         <= 1'b0;
            clip_count      <= 8'd0;
            ccnt            <= '0;
            idx             <= '0;
            x_q             <= '0;
            y_q             <= '0;
            clip_work       <= 8'd0;
        end else begin
            fs_q            <= frame_start;
            fb_write_en_q   <= wr_en_d;
            fb_write_data_q <= wr_data_d;
            fb_write_addr_q <= wr_addr_d;
            busy            <= busy_d;
            frame_done      <= done_d;

            // A start outside IDLE is only recorded; the running frame goes on.
            if (start && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) ccnt <= '0;
                end
                S_CLEAR: begin
                    ccnt <= ccnt + 1'b1;
                    if (clear_last) begin
                        idx       <= '0;
                        clip_work <= 8'd0;
                    end
                end
                S_WAIT: begin
                    x_q <= bus.boid_pos_x;
                    y_q <= bus.boid_pos_y;
                end
                S_WR: begin
                    if (!on_screen && (clip_work != 8'hff)) begin
                        clip_work <= clip_work + 8'd1;
                    end
                    if (!idx_last) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    clip_count <= clip_work;
                end
                default: ;
            endcase
        end
    end

endmodule
